// File: rtl/wishbone_sram_port.sv
// Wishbone classic slave that turns single cycles into OpenRAM single-port SRAM
// accesses. One registered csb0 pulse per request, a one-cycle ack, and a
// programmable number of edges between SRAM capture and read-data capture.
module wishbone_sram_port #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [3:0]            sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [31:0]           sram_din0,
  input  logic [31:0]           sram_dout0
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RWAIT = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_csb;
  logic                  r_web;
  logic [3:0]            r_wmask;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_din;
  logic                  r_ack;
  logic [31:0]           r_dat_o;

  logic                  w_req;
  logic                  w_unused_adr;

  // A request needs both the broadcast cycle and this port's gated strobe.
  assign w_req        = wbs_cyc_i & wbs_stb_i;
  // Upper address bits are decoded upstream; byte-lane bits are covered by sel.
  assign w_unused_adr = ^{wbs_adr_i[31:ADDR_WIDTH+2], wbs_adr_i[1:0]};

  // Access sequencer: csb0 pulse, read-latency wait, one-cycle ack, abort on cyc drop.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_csb   <= 1'b1;
      r_web   <= 1'b1;
      r_wmask <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_ack   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_csb <= 1'b1;
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr  <= wbs_adr_i[ADDR_WIDTH+1:2];
            r_din   <= wbs_dat_i;
            r_wmask <= wbs_sel_i;
            r_web   <= ~wbs_we_i;
            r_csb   <= 1'b0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (!wbs_cyc_i) begin
            r_state <= S_IDLE;
          end else if (!r_web) begin
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end else begin
            r_cnt   <= CNT_W'(READ_LATENCY - 1);
            r_state <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (!wbs_cyc_i) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_dat_o <= sram_dout0;
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_ACK: begin
          // A strobe still held high here is the tail of the cycle just acked.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat_o;
  assign sram_csb0   = r_csb;
  assign sram_web0   = r_web;
  assign sram_wmask0 = r_wmask;
  assign sram_addr0  = r_addr;
  assign sram_din0   = r_din;

endmodule

// File: tb/tb_wishbone_sram_port.sv
// Scoreboard bench for wishbone_sram_port: two ports (READ_LATENCY 1 and 3) share
// cyc/adr/dat/we/sel with per-port strobes, each backed by a behavioural SRAM.
module tb_wishbone_sram_port;

  localparam int unsigned RL0 = 1;
  localparam int unsigned RL1 = 3;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  addr;
    logic        web;
    logic [3:0]  wmask;
    logic [31:0] din;
  } acc_t;

  typedef struct {
    int unsigned cyc;
    logic        rd;
    logic [31:0] data;
  } ack_t;

  logic        clk;
  logic        rst_n;
  logic        cyc;
  logic        we;
  logic [1:0]  stb;
  logic [3:0]  sel;
  logic [31:0] dat;
  logic [31:0] adr;

  logic        ack   [2];
  logic [31:0] dat_o [2];
  logic        csb   [2];
  logic        web   [2];
  logic [3:0]  wmask [2];
  logic [7:0]  addr0 [2];
  logic [31:0] din   [2];

  int unsigned cyc_n = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  acc_t        acc_q [2][$];
  ack_t        ack_q [2][$];
  logic [31:0] ref_mem [256];
  logic [31:0] last_rd [2];
  logic [7:0]  h_addr  [2];
  logic        h_web   [2];
  logic [3:0]  h_wmask [2];
  logic [31:0] h_din   [2];
  logic [7:0]  addr_set [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  for (genvar g = 0; g < 2; g++) begin : g_port
    localparam int unsigned RL = (g == 0) ? RL0 : RL1;
    logic [31:0] dout;
    logic [31:0] rd;
    logic [31:0] mem [256];
    int unsigned left = 0;

    wishbone_sram_port #(.ADDR_WIDTH(8), .READ_LATENCY(RL)) u_dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst_n),
      .wbs_stb_i   (stb[g]),
      .wbs_cyc_i   (cyc),
      .wbs_we_i    (we),
      .wbs_sel_i   (sel),
      .wbs_dat_i   (dat),
      .wbs_adr_i   (adr),
      .wbs_ack_o   (ack[g]),
      .wbs_dat_o   (dat_o[g]),
      .sram_csb0   (csb[g]),
      .sram_web0   (web[g]),
      .sram_wmask0 (wmask[g]),
      .sram_addr0  (addr0[g]),
      .sram_din0   (din[g]),
      .sram_dout0  (dout)
    );

    // SRAM: captures on the edge csb0 is seen low; read data is only valid
    // from RL edges after capture until the next edge, garbage otherwise.
    always @(posedge clk) begin
      if (!csb[g]) begin
        if (!web[g]) begin
          for (int b = 0; b < 4; b++)
            if (wmask[g][b]) mem[addr0[g]][8*b +: 8] <= din[g][8*b +: 8];
          dout <= $urandom;
          left <= 0;
        end else if (RL == 1) begin
          dout <= mem[addr0[g]];
          left <= 0;
        end else begin
          rd   <= mem[addr0[g]];
          left <= RL - 1;
          dout <= $urandom;
        end
      end else if (left > 1) begin
        left <= left - 1;
        dout <= $urandom;
      end else if (left == 1) begin
        left <= 0;
        dout <= rd;
      end else begin
        dout <= $urandom;
      end
    end
  end

  task automatic chk(input string name, input int g, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at cycle %0d: got 0x%08h, expected 0x%08h",
               name, g, cyc_n, act, exp);
    end
  endtask

  function automatic int unsigned lat(input int g, input logic is_wr);
    int unsigned rl;
    rl = (g == 0) ? RL0 : RL1;
    return is_wr ? 2 : 2 + rl;
  endfunction

  // One Wishbone classic request on both ports; expectations pushed up front.
  task automatic do_req(input logic is_wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit hold, input bit abort);
    int unsigned req;
    int unsigned ae [2];
    logic [7:0]  wa;
    logic [31:0] exp_rd;
    acc_t        ea;
    ack_t        ek;
    @(posedge clk); #1;
    req = cyc_n + 1;
    wa  = 8'((a >> 2) & 32'hFF);
    exp_rd = ref_mem[wa];
    if (is_wr && !abort)
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[wa][8*b +: 8] = d[8*b +: 8];
    cyc = 1'b1; stb = 2'b11; we = is_wr; sel = s; dat = d; adr = a;
    for (int g = 0; g < 2; g++) begin
      ea.cyc = req; ea.addr = wa; ea.web = ~is_wr; ea.wmask = s; ea.din = d;
      acc_q[g].push_back(ea);
      ae[g] = req + lat(g, is_wr);
      if (!abort) begin
        ek.cyc = ae[g] - 1; ek.rd = ~is_wr; ek.data = exp_rd;
        ack_q[g].push_back(ek);
      end
    end
    if (abort) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 2'b00;
    end else begin
      do begin
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++)
          if (cyc_n + (hold ? 0 : 1) >= ae[g]) stb[g] = 1'b0;
      end while (stb != 2'b00);
      cyc = 1'b0;
    end
  endtask

  // Monitor: pops expectations when csb0/ack show up and checks held outputs.
  task automatic monitor();
    acc_t ea;
    ack_t ek;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (!rst_n) begin
          acc_q[g].delete();
          ack_q[g].delete();
          last_rd[g] = '0;
          h_addr[g] = '0; h_web[g] = 1'b1; h_wmask[g] = '0; h_din[g] = '0;
        end else begin
          if (!csb[g]) begin
            if (acc_q[g].size() == 0) begin
              chk("csb_unexpected", g, 32'(csb[g]), 32'd1);
            end else begin
              ea = acc_q[g].pop_front();
              chk("csb_cycle", g, cyc_n, ea.cyc);
              h_addr[g] = ea.addr; h_web[g] = ea.web; h_wmask[g] = ea.wmask; h_din[g] = ea.din;
            end
          end else if (acc_q[g].size() != 0 && cyc_n >= acc_q[g][0].cyc) begin
            chk("csb_missing", g, 32'(csb[g]), 32'd0);
            void'(acc_q[g].pop_front());
          end
          if (ack[g]) begin
            if (ack_q[g].size() == 0) begin
              chk("ack_unexpected", g, 32'(ack[g]), 32'd0);
            end else begin
              ek = ack_q[g].pop_front();
              chk("ack_cycle", g, cyc_n, ek.cyc);
              if (ek.rd) last_rd[g] = ek.data;
            end
          end else if (ack_q[g].size() != 0 && cyc_n >= ack_q[g][0].cyc) begin
            chk("ack_missing", g, 32'(ack[g]), 32'd1);
            void'(ack_q[g].pop_front());
          end
          chk("dat_o", g, dat_o[g], last_rd[g]);
          chk("addr0", g, 32'(addr0[g]), 32'(h_addr[g]));
          chk("web0", g, 32'(web[g]), 32'(h_web[g]));
          chk("wmask0", g, 32'(wmask[g]), 32'(h_wmask[g]));
          chk("din0", g, din[g], h_din[g]);
        end
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk({tag, "_csb0"}, g, 32'(csb[g]), 32'd1);
      chk({tag, "_ack"}, g, 32'(ack[g]), 32'd0);
      chk({tag, "_dat_o"}, g, dat_o[g], 32'd0);
    end
  endtask

  initial begin
    cyc = 1'b0; stb = 2'b00; we = 1'b0; sel = '0; dat = '0; adr = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset");
    for (int g = 0; g < 2; g++) begin
      chk("reset_web0", g, 32'(web[g]), 32'd1);
      chk("reset_wmask0", g, 32'(wmask[g]), 32'd0);
      chk("reset_addr0", g, 32'(addr0[g]), 32'd0);
      chk("reset_din0", g, din[g], 32'd0);
    end
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Basic write then read-back at word 4.
    do_req(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
    do_req(1'b0, 32'h3000_0010, $urandom, 4'hF, 1'b0, 1'b0);

    // Byte-lane merge, then an all-lanes-off write that must change nothing.
    do_req(1'b1, 32'h3000_0080, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
    do_req(1'b1, 32'h3000_0080, 32'hAAAA_AAAA, 4'h5, 1'b0, 1'b0);
    do_req(1'b0, 32'h3000_0080, 32'h0, 4'h0, 1'b0, 1'b0);
    do_req(1'b1, 32'h3000_0080, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b0);
    do_req(1'b0, 32'h3000_0080, 32'h0, 4'hF, 1'b1, 1'b0);

    // Master holding strobe through the ack edge.
    do_req(1'b1, 32'h3000_0040, 32'h0BAD_F00D, 4'hC, 1'b1, 1'b0);
    do_req(1'b0, 32'h3000_0040, 32'h0, 4'hF, 1'b1, 1'b0);

    // Aborted read, then a normal read.
    do_req(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b0, 1'b1);
    do_req(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b0, 1'b0);

    // Strobe without cycle must not start an access.
    @(posedge clk); #1;
    stb = 2'b11; we = 1'b1; sel = 4'hF; dat = 32'h5555_5555; adr = 32'h3000_0010;
    repeat (4) @(posedge clk);
    #1 stb = 2'b00;

    // Randomised traffic over a small address set.
    for (int i = 0; i < 16; i++) begin
      addr_set[i] = 8'(i * 16 + int'($urandom_range(0, 15)));
      do_req(1'b1, {$urandom, 2'b00} & 32'hFFFF_FC00 | 32'(addr_set[i]) << 2,
             $urandom, 4'hF, 1'b0, 1'b0);
    end
    for (int i = 0; i < 150; i++) begin
      logic        w;
      logic [7:0]  wa;
      logic [31:0] a;
      w  = 1'($urandom_range(0, 1));
      wa = addr_set[$urandom_range(0, 15)];
      a  = ($urandom & 32'hFFFF_FC03) | (32'(wa) << 2);
      do_req(w, a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             !w && ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset while a read is in flight: outputs drop before the next edge.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 2'b11; we = 1'b0; sel = 4'hF; adr = 32'h3000_0010;
    @(posedge clk); #2;
    for (int g = 0; g < 2; g++) chk("csb0_before_rst", g, 32'(csb[g]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    cyc = 1'b0; stb = 2'b00;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    do_req(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b0, 1'b0);

    repeat (10) @(posedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("acc_left", g, 32'(acc_q[g].size()), 32'd0);
      chk("ack_left", g, 32'(ack_q[g].size()), 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

endmodule
